// File: rtl/centroid_update_sched.sv
// centroid_update_sched: sequences one k-means centroid-update pass over a shared PointOps datapath.
// Ports: clk/reset_n; io_start; point stream io_in_* (valid/ready/x/y/cent/last);
// datapath io_op_* (operation, p1, p2, den out; pout in); converter io_conv_in/io_conv_out;
// centroid stream io_out_* (valid/ready/idx/x/y); status io_busy, io_done, io_dropped.
module centroid_update_sched #(
  parameter int K  = 3,
  parameter int CW = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_start,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [63:0] io_in_x,
  input  logic [63:0] io_in_y,
  input  logic [31:0] io_in_cent,
  input  logic        io_in_last,
  output logic [3:0]  io_op_operation,
  output logic [63:0] io_op_p1x,
  output logic [63:0] io_op_p1y,
  output logic [63:0] io_op_p2x,
  output logic [63:0] io_op_p2y,
  output logic [63:0] io_op_den,
  input  logic [63:0] io_op_poutx,
  input  logic [63:0] io_op_pouty,
  output logic [31:0] io_conv_in,
  input  logic [63:0] io_conv_out,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_idx,
  output logic [63:0] io_out_x,
  output logic [63:0] io_out_y,
  output logic        io_busy,
  output logic        io_done,
  output logic        io_dropped
);
  typedef enum logic [2:0] {IDLE, ACCUM, DIVIDE, EMIT, DONE} state_t;
  state_t state, state_n;
  logic [63:0] acc_x [K];
  logic [63:0] acc_y [K];
  logic [CW-1:0] count [K];
  logic [31:0] j;
  logic [63:0] sel_x, sel_y, div_x, div_y;
  logic [CW-1:0] sel_cnt, div_cnt;
  logic hit, accept, take;
  // Operand muxes: one by incoming label, one by the divide index.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_cnt = '0;
    div_x = '0;
    div_y = '0;
    div_cnt = '0;
    hit = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (io_in_cent == 32'(i)) begin
        hit = 1'b1;
        sel_x = acc_x[i];
        sel_y = acc_y[i];
        sel_cnt = count[i];
      end
      if (j == 32'(i)) begin
        div_x = acc_x[i];
        div_y = acc_y[i];
        div_cnt = count[i];
      end
    end
  end
  assign accept = state == ACCUM && io_in_valid;
  // A point updates only for a legal label whose counter cannot overflow.
  assign take = accept && hit && !(&sel_cnt);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = io_start ? ACCUM : IDLE;
      ACCUM:   state_n = (accept && io_in_last) ? DIVIDE : ACCUM;
      DIVIDE:  state_n = EMIT;
      EMIT:    state_n = !io_out_ready ? EMIT : (j == 32'(K - 1)) ? DONE : DIVIDE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    io_in_ready = state == ACCUM;
    io_out_valid = state == EMIT;
    io_busy = state != IDLE;
    io_done = state == DONE;
    io_op_operation = accept ? 4'd1 : (state == DIVIDE) ? 4'd3 : 4'hF;
    io_op_p1x = accept ? sel_x : (state == DIVIDE) ? div_x : '0;
    io_op_p1y = accept ? sel_y : (state == DIVIDE) ? div_y : '0;
    io_op_p2x = accept ? io_in_x : '0;
    io_op_p2y = accept ? io_in_y : '0;
    io_op_den = (state == DIVIDE) ? io_conv_out : '0;
    io_conv_in = (state == DIVIDE) ? 32'(div_cnt) : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < K; i++) begin
        acc_x[i] <= '0;
        acc_y[i] <= '0;
        count[i] <= '0;
      end
      j <= '0;
      io_dropped <= 1'b0;
      io_out_idx <= '0;
      io_out_x <= '0;
      io_out_y <= '0;
    end else begin
      if (state == IDLE && io_start) begin
        for (int i = 0; i < K; i++) begin
          acc_x[i] <= '0;
          acc_y[i] <= '0;
          count[i] <= '0;
        end
        j <= '0;
        io_dropped <= 1'b0;
      end
      if (accept && !take) io_dropped <= 1'b1;
      for (int i = 0; i < K; i++)
        if (take && io_in_cent == 32'(i)) begin
          acc_x[i] <= io_op_poutx;
          acc_y[i] <= io_op_pouty;
          count[i] <= count[i] + CW'(1);
        end
      // An empty cluster yields (0,0); the divider output would be 0/0.
      if (state == DIVIDE) begin
        io_out_idx <= j;
        io_out_x <= (div_cnt == '0) ? '0 : io_op_poutx;
        io_out_y <= (div_cnt == '0) ? '0 : io_op_pouty;
      end
      if (state == EMIT && io_out_ready) j <= j + 32'd1;
    end
endmodule

// File: tb/tb_centroid_update_sched.sv
// tb_centroid_update_sched: directed table-driven bench for centroid_update_sched with a PointOps model.
module tb_centroid_update_sched;
  localparam int K = 3;
  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic [31:0] c;
    logic last;
    logic drop;
  } pt_t;
  typedef struct {
    logic [31:0] idx;
    logic [63:0] x;
    logic [63:0] y;
    logic [31:0] cnt;
  } exp_t;
  logic clk = 1'b0, reset_n = 1'b0, io_start = 1'b0, io_in_valid = 1'b0, io_in_last = 1'b0, io_out_ready = 1'b0;
  logic [63:0] io_in_x = '0, io_in_y = '0;
  logic [31:0] io_in_cent = '0;
  logic io_in_ready, io_out_valid, io_busy, io_done, io_dropped;
  logic [3:0] io_op_operation;
  logic [63:0] io_op_p1x, io_op_p1y, io_op_p2x, io_op_p2y, io_op_den, io_op_poutx, io_op_pouty, io_conv_out, io_out_x, io_out_y;
  logic [31:0] io_conv_in, io_out_idx;
  int n_chk = 0, n_fail = 0;
  pt_t pts [9];
  exp_t exps [9];
  centroid_update_sched #(.K(K), .CW(16)) dut (
    .clk(clk), .reset_n(reset_n), .io_start(io_start),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_x(io_in_x), .io_in_y(io_in_y),
    .io_in_cent(io_in_cent), .io_in_last(io_in_last),
    .io_op_operation(io_op_operation), .io_op_p1x(io_op_p1x), .io_op_p1y(io_op_p1y),
    .io_op_p2x(io_op_p2x), .io_op_p2y(io_op_p2y), .io_op_den(io_op_den),
    .io_op_poutx(io_op_poutx), .io_op_pouty(io_op_pouty),
    .io_conv_in(io_conv_in), .io_conv_out(io_conv_out),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready), .io_out_idx(io_out_idx),
    .io_out_x(io_out_x), .io_out_y(io_out_y),
    .io_busy(io_busy), .io_done(io_done), .io_dropped(io_dropped)
  );
  always #5 clk = ~clk;
  always_comb begin
    io_op_poutx = '0;
    io_op_pouty = '0;
    if (io_op_operation == 4'd1) begin
      io_op_poutx = $realtobits($bitstoreal(io_op_p1x) + $bitstoreal(io_op_p2x));
      io_op_pouty = $realtobits($bitstoreal(io_op_p1y) + $bitstoreal(io_op_p2y));
    end else if (io_op_operation == 4'd3 && io_op_den != '0) begin
      io_op_poutx = $realtobits($bitstoreal(io_op_p1x) / $bitstoreal(io_op_den));
      io_op_pouty = $realtobits($bitstoreal(io_op_p1y) / $bitstoreal(io_op_den));
    end
  end
  assign io_conv_out = $realtobits(real'(io_conv_in));
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic start_pass();
    io_start = 1'b1;
    @(negedge clk);
    io_start = 1'b0;
    chk("busy_after_start", 64'(io_busy), 64'd1);
  endtask
  task automatic send(input pt_t p);
    io_in_valid = 1'b1;
    io_in_x = p.x;
    io_in_y = p.y;
    io_in_cent = p.c;
    io_in_last = p.last;
    chk("in_ready", 64'(io_in_ready), 64'd1);
    @(negedge clk);
    chk("dropped", 64'(io_dropped), 64'(p.drop));
  endtask
  task automatic get_out(input exp_t e, input int hold, input bit poke);
    int w = 0;
    chk("op_divide", 64'(io_op_operation), 64'd3);
    chk("conv_in", 64'(io_conv_in), 64'(e.cnt));
    if (poke) io_start = 1'b1;
    do begin
      @(negedge clk);
      w++;
    end while (!io_out_valid && w < 8);
    io_start = 1'b0;
    chk("out_latency", 64'(w), 64'd1);
    chk("out_idx", 64'(io_out_idx), 64'(e.idx));
    chk("out_x", io_out_x, e.x);
    chk("out_y", io_out_y, e.y);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(io_out_valid), 64'd1);
      chk("hold_idx", 64'(io_out_idx), 64'(e.idx));
      chk("hold_x", io_out_x, e.x);
      chk("hold_y", io_out_y, e.y);
      chk("hold_op_idle", 64'(io_op_operation), 64'hF);
    end
    io_out_ready = 1'b1;
    @(negedge clk);
    io_out_ready = 1'b0;
  endtask
  task automatic run_pass(input int p0, input int e0, input int hold_idx, input bit poke);
    start_pass();
    for (int i = p0; i < p0 + 3; i++) send(pts[i]);
    io_in_valid = 1'b0;
    io_in_last = 1'b0;
    for (int k = 0; k < K; k++) get_out(exps[e0 + k], (k == hold_idx) ? 5 : 0, poke && k == 0);
    chk("done_pulse", 64'(io_done), 64'd1);
    chk("busy_in_done", 64'(io_busy), 64'd1);
    @(negedge clk);
    chk("done_low", 64'(io_done), 64'd0);
    chk("busy_low", 64'(io_busy), 64'd0);
  endtask
  initial begin
    pts[0] = '{$realtobits(1.0), $realtobits(1.0), 32'd0, 1'b0, 1'b0};
    pts[1] = '{$realtobits(3.0), $realtobits(3.0), 32'd0, 1'b0, 1'b0};
    pts[2] = '{$realtobits(2.0), $realtobits(4.0), 32'd1, 1'b1, 1'b0};
    pts[3] = '{$realtobits(1.0), $realtobits(1.0), 32'd2, 1'b0, 1'b0};
    pts[4] = '{$realtobits(1.0), $realtobits(1.0), 32'd2, 1'b0, 1'b0};
    pts[5] = '{$realtobits(1.0), $realtobits(1.0), 32'd2, 1'b1, 1'b0};
    pts[6] = '{$realtobits(1.0), $realtobits(3.0), 32'd1, 1'b0, 1'b0};
    pts[7] = '{$realtobits(9.0), $realtobits(9.0), 32'd7, 1'b0, 1'b1};
    pts[8] = '{$realtobits(3.0), $realtobits(5.0), 32'd1, 1'b1, 1'b1};
    exps[0] = '{32'd0, 64'h4000000000000000, 64'h4000000000000000, 32'd2};
    exps[1] = '{32'd1, $realtobits(2.0), $realtobits(4.0), 32'd1};
    exps[2] = '{32'd2, 64'd0, 64'd0, 32'd0};
    exps[3] = '{32'd0, 64'd0, 64'd0, 32'd0};
    exps[4] = '{32'd1, 64'd0, 64'd0, 32'd0};
    exps[5] = '{32'd2, $realtobits(1.0), $realtobits(1.0), 32'd3};
    exps[6] = '{32'd0, 64'd0, 64'd0, 32'd0};
    exps[7] = '{32'd1, $realtobits(2.0), $realtobits(4.0), 32'd2};
    exps[8] = '{32'd2, 64'd0, 64'd0, 32'd0};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(io_in_ready), 64'd0);
    chk("rst_out_valid", 64'(io_out_valid), 64'd0);
    chk("rst_busy", 64'(io_busy), 64'd0);
    chk("rst_done", 64'(io_done), 64'd0);
    chk("rst_dropped", 64'(io_dropped), 64'd0);
    chk("rst_op", 64'(io_op_operation), 64'hF);
    chk("rst_conv_in", 64'(io_conv_in), 64'd0);
    chk("rst_out_x", io_out_x, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    run_pass(0, 0, -1, 1'b0);
    chk("pass1_dropped", 64'(io_dropped), 64'd0);
    run_pass(3, 3, -1, 1'b1);
    run_pass(6, 6, 1, 1'b0);
    chk("pass3_dropped_sticky", 64'(io_dropped), 64'd1);
    start_pass();
    chk("start_clears_dropped", 64'(io_dropped), 64'd0);
    send(pts[0]);
    send(pts[1]);
    io_in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(io_in_ready), 64'd0);
    chk("arst_busy", 64'(io_busy), 64'd0);
    chk("arst_op", 64'(io_op_operation), 64'hF);
    chk("arst_p1x", io_op_p1x, 64'd0);
    chk("arst_out_idx", 64'(io_out_idx), 64'd0);
    chk("arst_out_x", io_out_x, 64'd0);
    @(negedge clk);
    chk("arst_done", 64'(io_done), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    run_pass(0, 0, -1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
